// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage inputs and forwarding/stall/halt outputs of fwd_hazard_ctrl (o_stall_count only with FWD_STALL_COUNT_EN)
interface fwd_hazard_ctrl_if #(
  parameter int NB_REG = 5
`ifdef FWD_STALL_COUNT_EN
  , parameter int NB_STALL_CNT = 32
`endif
);
  logic              i_enable;
  logic              i_id_valid;
  logic [NB_REG-1:0] i_id_rs;
  logic [NB_REG-1:0] i_id_rt;
  logic              i_id_uses_rt;
  logic [NB_REG-1:0] i_id_rd;
  logic              i_id_reg_write;
  logic              i_id_mem_read;
  logic              i_id_halt;
  logic              o_stall;
  logic [1:0]        o_fwd_a_sel;
  logic [1:0]        o_fwd_b_sel;
  logic              o_halted;
`ifdef FWD_STALL_COUNT_EN
  logic [NB_STALL_CNT-1:0] o_stall_count;
`endif
  modport master (
    output i_enable, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rt, i_id_rd,
           i_id_reg_write, i_id_mem_read, i_id_halt,
    input  o_stall, o_fwd_a_sel, o_fwd_b_sel, o_halted
`ifdef FWD_STALL_COUNT_EN
    , input o_stall_count
`endif
  );
  modport slave (
    input  i_enable, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rt, i_id_rd,
           i_id_reg_write, i_id_mem_read, i_id_halt,
    output o_stall, o_fwd_a_sel, o_fwd_b_sel, o_halted
`ifdef FWD_STALL_COUNT_EN
    , output o_stall_count
`endif
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage forwarding selectors, load-use stall and HALT drain sequencer.
// Defining FWD_STALL_COUNT_EN adds the saturating o_stall_count output.
module fwd_hazard_ctrl #(
  parameter int NB_REG       = 5,
  parameter int DRAIN_CYCLES = 3
`ifdef FWD_STALL_COUNT_EN
  , parameter int NB_STALL_CNT = 32
`endif
) (
  input logic              i_clk,
  input logic              i_reset,
  fwd_hazard_ctrl_if.slave bus
);
  localparam int NB_CNT = $clog2(DRAIN_CYCLES) + 1;
  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
  state_t            state_q, state_d;
  logic              ex_w_q, ex_ld_q, mem_w_q;
  logic [NB_REG-1:0] ex_rd_q, mem_rd_q;
  logic [1:0]        a_q, a_d, b_q, b_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              active, load_use, ins, halt_acc;
  // STALL accepts ID like RUN: the bubble was already inserted on the stalling edge
  always_comb begin
    active   = state_q == RUN || state_q == STALL;
    load_use = bus.i_id_valid && ex_ld_q && |ex_rd_q &&
               (ex_rd_q == bus.i_id_rs || (bus.i_id_uses_rt && ex_rd_q == bus.i_id_rt));
    halt_acc = active && !load_use && bus.i_id_valid && bus.i_id_halt;
    ins      = active && !load_use && bus.i_id_valid && !bus.i_id_halt;
    a_d      = !ins || bus.i_id_rs == '0 ? 2'b00 :
               ex_w_q && ex_rd_q == bus.i_id_rs ? 2'b01 :
               mem_w_q && mem_rd_q == bus.i_id_rs ? 2'b10 : 2'b00;
    b_d      = !ins || !bus.i_id_uses_rt || bus.i_id_rt == '0 ? 2'b00 :
               ex_w_q && ex_rd_q == bus.i_id_rt ? 2'b01 :
               mem_w_q && mem_rd_q == bus.i_id_rt ? 2'b10 : 2'b00;
    state_d  = halt_acc ? DRAIN : active ? (load_use ? STALL : RUN) :
               state_q == DRAIN && cnt_q == '0 ? HALTED : state_q;
    cnt_d    = halt_acc ? NB_CNT'(DRAIN_CYCLES - 1) :
               state_q == DRAIN && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= RUN;
      ex_w_q   <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_w_q  <= 1'b0;
      mem_rd_q <= '0;
      a_q      <= 2'b00;
      b_q      <= 2'b00;
      cnt_q    <= '0;
    end else if (bus.i_enable) begin
      state_q  <= state_d;
      ex_w_q   <= ins && bus.i_id_reg_write;
      ex_ld_q  <= ins && bus.i_id_mem_read;
      ex_rd_q  <= bus.i_id_rd;
      mem_w_q  <= ex_w_q;
      mem_rd_q <= ex_rd_q;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.o_stall     = active ? load_use : 1'b1;
  assign bus.o_fwd_a_sel = a_q;
  assign bus.o_fwd_b_sel = b_q;
  assign bus.o_halted    = state_q == HALTED;
`ifdef FWD_STALL_COUNT_EN
  logic [NB_STALL_CNT-1:0] scnt_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) scnt_q <= '0;
    else if (bus.i_enable && state_q == STALL && !(&scnt_q)) scnt_q <= scnt_q + 1'b1;
  end
  assign bus.o_stall_count = scnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios plus randomized traffic checked against a queue-based pipeline model
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  fwd_hazard_ctrl_if bus ();
  fwd_hazard_ctrl dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  typedef struct {logic v; logic [4:0] rd; logic rw; logic mr;} ins_t;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic hl);
    bus.i_id_valid = v;
    bus.i_id_rs = rs;
    bus.i_id_rt = rt;
    bus.i_id_uses_rt = ut;
    bus.i_id_rd = rd;
    bus.i_id_reg_write = rw;
    bus.i_id_mem_read = mr;
    bus.i_id_halt = hl;
    #1;
  endtask
  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_enable = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask
  // youngest matching producer: EX slot forwards from EX/MEM (01), MEM slot from MEM/WB (10)
  function automatic logic [1:0] fwd(input ins_t h0, input ins_t h1, input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (h0.v && h0.rw && h0.rd == src) return 2'b01;
    if (h1.v && h1.rw && h1.rd == src) return 2'b10;
    return 2'b00;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    bus.i_enable = 1'b1;
    set_id(1, 3, 3, 1, 3, 1, 1, 0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    n_checks++; if (bus.o_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL reset_a_sel: got %b want 00", bus.o_fwd_a_sel); end
    n_checks++; if (bus.o_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL reset_b_sel: got %b want 00", bus.o_fwd_b_sel); end
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.o_stall); end
    n_checks++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.o_halted); end
  endtask
  task automatic test_forward();
    do_reset();
    set_id(1, 1, 2, 1, 3, 1, 0, 0);
    tick();
    set_id(1, 3, 4, 1, 6, 1, 0, 0);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b want 0", bus.o_stall); end
    tick();
    set_id(1, 3, 0, 0, 8, 1, 0, 0);
    n_checks++; if (bus.o_fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL fwd_ex_a: got %b want 01", bus.o_fwd_a_sel); end
    n_checks++; if (bus.o_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL fwd_ex_b: got %b want 00", bus.o_fwd_b_sel); end
    tick();
    idle();
    n_checks++; if (bus.o_fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_a: got %b want 10", bus.o_fwd_a_sel); end
    n_checks++; if (bus.o_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL fwd_mem_b: got %b want 00", bus.o_fwd_b_sel); end
  endtask
  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 0, 0, 5, 1, 1, 0);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %b want 0", bus.o_stall); end
    tick();
    set_id(1, 1, 5, 1, 9, 1, 0, 0);
    n_checks++; if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_on: got %b want 1", bus.o_stall); end
    tick();
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_off: got %b want 0", bus.o_stall); end
    n_checks++; if ({bus.o_fwd_a_sel, bus.o_fwd_b_sel} !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_sel: got %b want 0000", {bus.o_fwd_a_sel, bus.o_fwd_b_sel}); end
    tick();
    idle();
    n_checks++; if (bus.o_fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL lu_b_sel: got %b want 10", bus.o_fwd_b_sel); end
    n_checks++; if (bus.o_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL lu_a_sel: got %b want 00", bus.o_fwd_a_sel); end
`ifdef FWD_STALL_COUNT_EN
    n_checks++; if (bus.o_stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_stall_count: got %0d want 1", bus.o_stall_count); end
`endif
  endtask
  task automatic test_stall_halt();
    do_reset();
    set_id(1, 2, 0, 0, 5, 1, 1, 0);
    tick();
    set_id(1, 5, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL sh_stall_first: got %b want 1", bus.o_stall); end
    tick();
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL sh_halt_accept: got %b want 0", bus.o_stall); end
    tick();
    idle();
    n_checks++; if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL sh_drain_stall: got %b want 1", bus.o_stall); end
  endtask
  task automatic test_r0();
    do_reset();
    set_id(1, 1, 1, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 1, 4, 1, 0, 0);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", bus.o_stall); end
    tick();
    set_id(1, 1, 2, 0, 0, 1, 1, 0);
    n_checks++; if ({bus.o_fwd_a_sel, bus.o_fwd_b_sel} !== 4'b0000) begin n_fail++; $display("FAIL r0_sel: got %b want 0000", {bus.o_fwd_a_sel, bus.o_fwd_b_sel}); end
    tick();
    set_id(1, 0, 0, 1, 6, 1, 0, 0);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL r0_load_stall: got %b want 0", bus.o_stall); end
    tick();
    idle();
  endtask
  task automatic test_halt(input int dis);
    int first;
    do_reset();
    set_id(1, 1, 2, 1, 7, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL halt_issue_stall: got %b want 0", bus.o_stall); end
    tick();
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      bus.i_enable = !(n >= 2 && n < 2 + dis);
      set_id(1, 7, 7, 1, 9, 1, 0, 0);
      if (first == 0) begin
        n_checks++; if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL halt_drain_stall n=%0d: got %b want 1", n, bus.o_stall); end
        if (bus.o_halted === 1'b1) first = n;
      end
      tick();
    end
    bus.i_enable = 1'b1;
    idle();
    n_checks++; if (first != 4 + dis) begin n_fail++; $display("FAIL halt_latency dis=%0d: got %0d want %0d", dis, first, 4 + dis); end
  endtask
  task automatic test_reset_drain();
    do_reset();
    set_id(1, 1, 2, 1, 7, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    n_checks++; if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL rd_in_drain: got %b want 1", bus.o_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({bus.o_stall, bus.o_halted} !== 2'b00) begin n_fail++; $display("FAIL rd_flags: got %b want 00", {bus.o_stall, bus.o_halted}); end
    n_checks++; if ({bus.o_fwd_a_sel, bus.o_fwd_b_sel} !== 4'b0000) begin n_fail++; $display("FAIL rd_sel: got %b want 0000", {bus.o_fwd_a_sel, bus.o_fwd_b_sel}); end
    set_id(1, 1, 1, 0, 2, 1, 0, 0);
    tick();
    set_id(1, 2, 0, 0, 3, 1, 0, 0);
    n_checks++; if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL rd_accept_stall: got %b want 0", bus.o_stall); end
    tick();
    idle();
    n_checks++; if (bus.o_fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL rd_accept_a: got %b want 01", bus.o_fwd_a_sel); end
  endtask
  task automatic test_random();
    ins_t hist[$];
    ins_t e;
    logic [1:0] ea, eb;
    logic es, v, ut, rw, mr, en, in_st;
    logic [4:0] rs, rt, rd;
    int scnt;
    do_reset();
    e = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    hist = {e, e};
    ea = 2'b00;
    eb = 2'b00;
    scnt = 0;
    in_st = 1'b0;
    repeat (400) begin
      v = $urandom_range(0, 3) != 0;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      ut = 1'($urandom_range(0, 1));
      mr = $urandom_range(0, 2) == 0;
      rw = mr | 1'($urandom_range(0, 1));
      en = $urandom_range(0, 9) != 0;
      bus.i_enable = en;
      set_id(v, rs, rt, ut, rd, rw, mr, 0);
      es = v && hist[0].v && hist[0].mr && hist[0].rd != 0 && (hist[0].rd == rs || (ut && hist[0].rd == rt));
      n_checks++; if (bus.o_stall !== es) begin n_fail++; $display("FAIL rnd_stall: got %b want %b", bus.o_stall, es); end
      n_checks++; if (bus.o_fwd_a_sel !== ea) begin n_fail++; $display("FAIL rnd_a_sel: got %b want %b", bus.o_fwd_a_sel, ea); end
      n_checks++; if (bus.o_fwd_b_sel !== eb) begin n_fail++; $display("FAIL rnd_b_sel: got %b want %b", bus.o_fwd_b_sel, eb); end
      n_checks++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL rnd_halted: got %b want 0", bus.o_halted); end
      tick();
      if (en) begin
        if (in_st) scnt++;
        in_st = es;
        e = '{v: v && !es, rd: rd, rw: rw, mr: mr};
        ea = e.v ? fwd(hist[0], hist[1], rs) : 2'b00;
        eb = e.v && ut ? fwd(hist[0], hist[1], rt) : 2'b00;
        hist.push_front(e);
        void'(hist.pop_back());
      end
    end
    bus.i_enable = 1'b1;
    idle();
`ifdef FWD_STALL_COUNT_EN
    n_checks++; if (bus.o_stall_count !== 32'(scnt)) begin n_fail++; $display("FAIL rnd_stall_count: got %0d want %0d", bus.o_stall_count, scnt); end
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.i_enable = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_stall_halt();
    test_r0();
    test_halt(0);
    test_halt(4);
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
